setuphold_capture: RTL and testbench

SETUPHOLD_CAPTURE -- requirements
Module: setuphold_capture

---
 rtl/setuphold_pkg.sv | 16 +
 rtl/setuphold_sat_counter.sv | 23 ++
 rtl/setuphold_capture.sv | 99 +++++++++
 tb/tb_setuphold_capture.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/setuphold_pkg.sv
// setuphold_pkg: shared state encoding and default constants for the
// setuphold_capture block and its violation counter.
package setuphold_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } sh_state_e;

  localparam int WIDTH_DEF       = 1;
  localparam int VCNT_W_DEF      = 8;
  localparam int RECOVER_CYC_DEF = 2;
  // The recovery counter only ever holds 0..RECOVER_CYC, and RECOVER_CYC <= 255.
  localparam int RC_W            = 8;

endpackage

// File: rtl/setuphold_sat_counter.sv
// setuphold_sat_counter: saturating up-counter with synchronous clear.
// When clear and increment coincide, the increment is kept, so the count lands on 1.
module setuphold_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear has priority over saturation, but never drops a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= inc ? W'(1) : '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/setuphold_capture.sv
// setuphold_capture: captures delayed data behind a $setuphold stage.
// Each NTFR toggle is one timing violation. A violation withholds Q for
// RECOVER_CYC cycles (HOLD), and VCNT counts the violations.
// Optional build macro SETUPHOLD_CAPTURE_XPROP_EN: Q reads all-x while VIOL is high.
module setuphold_capture
  import setuphold_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int VCNT_W      = VCNT_W_DEF,
  parameter int RECOVER_CYC = RECOVER_CYC_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WIDTH-1:0]  dD,
  input  logic              NTFR,
  input  logic              CLR,
  output logic [WIDTH-1:0]  Q,
  output logic              QV,
  output logic              VIOL,
  output logic [VCNT_W-1:0] VCNT
);

  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYC);

  logic             ntf_q;
  logic             ev;
  sh_state_e        state, state_nxt;
  logic [RC_W-1:0]  rc, rc_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             qv_r, qv_nxt;

  assign ev = NTFR ^ ntf_q;

  // State, recovery counter, capture and notifier registers. During reset,
  // ntf_q tracks NTFR so that releasing reset cannot look like a toggle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= RUN;
      rc    <= '0;
      q_r   <= '0;
      qv_r  <= 1'b0;
      ntf_q <= NTFR;
    end else begin
      state <= state_nxt;
      rc    <= rc_nxt;
      q_r   <= q_nxt;
      qv_r  <= qv_nxt;
      ntf_q <= NTFR;
    end
  end

  // Next state: capture in RUN, count down in HOLD, and reload on every new violation.
  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    q_nxt     = q_r;
    qv_nxt    = qv_r;
    case (state)
      RUN: begin
        if (ev) begin
          state_nxt = HOLD;
          rc_nxt    = RC_LOAD;
          qv_nxt    = 1'b0;
        end else begin
          q_nxt  = dD;
          qv_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (ev) begin
          rc_nxt = RC_LOAD;
        end else begin
          rc_nxt = rc - 1'b1;
          // QV stays low here. The first fresh capture happens in RUN on the next edge.
          if (rc == RC_W'(1)) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign VIOL = (state == HOLD);
  assign QV   = qv_r;

`ifdef SETUPHOLD_CAPTURE_XPROP_EN
  assign Q = VIOL ? {WIDTH{1'bx}} : q_r;
`else
  assign Q = q_r;
`endif

  setuphold_sat_counter #(.W(VCNT_W)) u_vcnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (ev),
    .clr   (CLR),
    .cnt   (VCNT)
  );

endmodule

// File: tb/tb_setuphold_capture.sv
// tb_setuphold_capture: directed vectors with hand-computed expectations.
// Covers reset, capture, single and retriggered violations, counter saturation
// and clear, and reset during HOLD.
module tb_setuphold_capture;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [W-1:0]  dD;
  logic          NTFR;
  logic          CLR;
  logic [W-1:0]  Q;
  logic          QV;
  logic          VIOL;
  logic [CW-1:0] VCNT;

  int checks   = 0;
  int failures = 0;

  setuphold_capture #(.WIDTH(W), .VCNT_W(CW), .RECOVER_CYC(2)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .dD   (dD),
    .NTFR (NTFR),
    .CLR  (CLR),
    .Q    (Q),
    .QV   (QV),
    .VIOL (VIOL),
    .VCNT (VCNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value Q should show while VIOL is high (the held value unless x-propagation is built in).
  function automatic logic [W-1:0] qhold(input logic [W-1:0] v);
`ifdef SETUPHOLD_CAPTURE_XPROP_EN
    return {W{1'bx}};
`else
    return v;
`endif
  endfunction

  // Step one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; dD = '0; NTFR = 1'b0; CLR = 1'b0;
    tick(); tick();
    chk("rst_q",    Q,    4'h0);
    chk("rst_qv",   QV,   1'b0);
    chk("rst_viol", VIOL, 1'b0);
    chk("rst_vcnt", VCNT, 2'd0);

    // Release, then capture with 1-cycle latency.
    RST_N = 1'b1; dD = 4'h1;
    tick();
    chk("cap1_q",    Q,    4'h1);
    chk("cap1_qv",   QV,   1'b1);
    chk("cap1_vcnt", VCNT, 2'd0);
    dD = 4'hA; tick(); chk("capA_q", Q, 4'hA);
    dD = 4'h5; tick(); chk("cap5_q", Q, 4'h5);
    dD = 4'h1; tick(); chk("capB_q", Q, 4'h1);

    // Single violation: VIOL for 2 cycles, then one RUN cycle before the capture.
    NTFR = 1'b1; dD = 4'h0;
    tick();
    chk("sv0_viol", VIOL, 1'b1);
    chk("sv0_qv",   QV,   1'b0);
    chk("sv0_q",    Q,    qhold(4'h1));
    chk("sv0_vcnt", VCNT, 2'd1);
    tick();
    chk("sv1_viol", VIOL, 1'b1);
    chk("sv1_qv",   QV,   1'b0);
    chk("sv1_q",    Q,    qhold(4'h1));
    tick();
    chk("sv2_viol", VIOL, 1'b0);
    chk("sv2_qv",   QV,   1'b0);
    chk("sv2_q",    Q,    4'h1);
    tick();
    chk("sv3_q",  Q,  4'h0);
    chk("sv3_qv", QV, 1'b1);
    chk("sv3_vcnt", VCNT, 2'd1);

    // CLR alone zeroes the count.
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("clr0_vcnt", VCNT, 2'd0);

    // Retrigger: two toggles on back-to-back cycles give 3 cycles of HOLD.
    NTFR = 1'b0; tick();
    chk("rt0_viol", VIOL, 1'b1);
    chk("rt0_vcnt", VCNT, 2'd1);
    NTFR = 1'b1; tick();
    chk("rt1_viol", VIOL, 1'b1);
    chk("rt1_vcnt", VCNT, 2'd2);
    tick(); chk("rt2_viol", VIOL, 1'b1);
    tick(); chk("rt3_viol", VIOL, 1'b0);
    chk("rt3_vcnt", VCNT, 2'd2);

    // Saturation: clear, then 5 consecutive toggles on a 2-bit counter.
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("clr1_vcnt", VCNT, 2'd0);
    for (int i = 0; i < 5; i++) begin
      NTFR = ~NTFR; tick();
    end
    chk("sat_vcnt", VCNT, 2'd3);
    chk("sat_viol", VIOL, 1'b1);

    // CLR together with a toggle gives 1, and CLR alone gives 0.
    CLR = 1'b1; NTFR = ~NTFR; tick();
    chk("clrev_vcnt", VCNT, 2'd1);
    tick(); CLR = 1'b0;
    chk("clronly_vcnt", VCNT, 2'd0);
    dD = 4'h9;
    tick();
    chk("rec_viol", VIOL, 1'b0);
    tick();
    chk("rec_q",  Q,  4'h9);
    chk("rec_qv", QV, 1'b1);

    // Reset during HOLD aborts recovery. NTFR stays at 1 across release.
    NTFR = ~NTFR; tick();
    chk("mh_viol", VIOL, 1'b1);
    RST_N = 1'b0; NTFR = 1'b1; tick();
    chk("mhr_q",    Q,    4'h0);
    chk("mhr_qv",   QV,   1'b0);
    chk("mhr_viol", VIOL, 1'b0);
    chk("mhr_vcnt", VCNT, 2'd0);
    RST_N = 1'b1; dD = 4'h7; tick();
    chk("mhx_viol", VIOL, 1'b0);
    chk("mhx_vcnt", VCNT, 2'd0);
    chk("mhx_q",    Q,    4'h7);
    chk("mhx_qv",   QV,   1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
